color_sequencer: RTL
====================

# color_sequencer

Frame-synchronous controller for the 3-bit colour datapath of the VGA colour clock. Counts frames from the sync generator's v_sync and advances the displayed colour after a programmable dwell. Supports enable, pause and single-step, and changes colour only at frame boundaries so there is no mid-frame tearing. Sits between the hvsync generator and the VGA pins, and drives the registered R/G/B plus the re-aligned sync outputs.

## Interface
- DWELL_FRAMES, 60, frames per colour; legal range 1..2^CNT_W.
- CNT_W, 8, width of the frame counter.
- clk  in  1  pixel clock, the same divided clock that drives the hvsync generator; all logic on its rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- h_sync  in  1  from the sync generator, active-low.
- v_sync  in  1  from the sync generator, active-low.
- onscreen  in  1  visible-area flag from the sync generator.
- en  in  1  level; 0 forces IDLE.
- pause  in  1  level; freezes dwell counting while in RUN/PAUSE.
- step  in  1  pulse; requests one colour advance while paused.
- color  out  3  current colour index.
- frame_tick  out  1  one-cycle pulse at each v_sync falling edge.
- R, G, B  out  1 each  pixel outputs.
- h_sync_o, v_sync_o  out  1 each  sync outputs delayed to align with R/G/B.

## Operation
- **Edge detect.** vs_q <= v_sync. frame_tick = vs_q & ~v_sync, registered to give a one-cycle pulse.
- **FSM states.** IDLE, RUN, PAUSE.
- **IDLE.**
  - color=0, cnt=0, step_pend=0.
  - Go to RUN when en=1.
- **RUN.**
  - On frame_tick: if cnt==DWELL_FRAMES-1 then cnt<=0 and color<=color+1; else cnt<=cnt+1.
  - step is ignored.
  - pause=1 -> PAUSE.
- **PAUSE.**
  - cnt is frozen.
  - step=1 sets step_pend. Several steps before a tick collapse to one.
  - On frame_tick with step_pend: color<=color+1, step_pend<=0, cnt unchanged.
  - pause=0 -> RUN, with step_pend cleared (discarded).
  - Counting resumes from the frozen cnt.
- **en=0 in any state** -> IDLE next cycle. This has priority over pause, step and tick.
- **Colour arithmetic.** Modulo 8: 7 -> 0.
- **DWELL_FRAMES=1.** Colour advances on every tick.
- **Simultaneous events.**
  - Tick in the same cycle as a pause rise: the tick is processed by RUN rules, then the FSM enters PAUSE.
  - step in the same cycle as a tick while in PAUSE: that tick advances colour, and the new step_pend is set for the next tick.
- **Outputs.**
  - R <= onscreen & color[2], G <= onscreen & color[1], B <= onscreen & color[0].
  - h_sync_o <= h_sync, v_sync_o <= v_sync.
- **Reset values** (rst_n low at a clock edge; takes effect at that edge, including mid-frame or mid-dwell):
  - state=IDLE, color=0, cnt=0, step_pend=0, frame_tick=0, R=G=B=0.
  - vs_q=0, so there is no spurious tick on release even if v_sync is low.
  - h_sync_o=1, v_sync_o=1.

## Timing
- frame_tick is asserted 1 clk after the first cycle v_sync is sampled low. Registered pulse, exactly one clk wide.
- color updates on the clk edge where frame_tick is high.
- R/G/B reflect a colour change from the next clk.
- R/G/B and h_sync_o/v_sync_o lag their inputs by exactly 1 clk, so they stay mutually aligned.
- en deassert -> color=0 one clk later.
- pause/step are sampled every clk. A step pulse needs only one clk.
- Colour period in RUN = DWELL_FRAMES frames exactly, with no off-by-one at wrap.

## Structure
- **Package color_clock_pkg:**
  - COLOR_W=3.
  - state enum seq_state_t {IDLE, RUN, PAUSE}.
  - color_t typedef (logic [COLOR_W-1:0]).
- **Sub-module frame_tick_det:**
  - Input: v_sync, with clk/rst_n. Output: registered falling-edge pulse.
  - Reusable for other frame-synchronous controllers.
- **Remainder:** one always block for the FSM/counters, one for the output registers.

## Test plan
- Reset, en=1, DWELL_FRAMES=3, 25 frame ticks -> color advances on ticks 3,6,…,24. Value sequence 0,1,…,7,0. Exactly 3 ticks per colour.
- Paused after color=2, no step for 10 ticks -> color stays 2, cnt frozen. Release pause -> next change after the remaining dwell, not a full dwell.
- While paused, 3 step pulses between ticks -> single advance (2→3) at the next tick. Another step in the same cycle as that tick -> 3→4 at the following tick.
- en dropped mid-dwell with color=5 -> color=0 next clk and R=G=B=0. Re-enable -> full dwell before color=1.
- rst_n low for one clk while v_sync is low and color=6 -> all outputs take their reset values. No frame_tick on release until v_sync rises and falls again.
- onscreen toggling with color=5 -> R=1, G=0, B=1 only when onscreen was 1 the previous clk. h_sync_o/v_sync_o equal h_sync/v_sync delayed 1 clk.

Source files
------------

// File: rtl/color_clock_pkg.sv
// rtl/color_clock_pkg.sv - shared types for the frame-synchronous colour sequencer
package color_clock_pkg;

  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  typedef logic [COLOR_W-1:0] color_t;

  // Next colour index; the natural wrap of COLOR_W bits gives 7 -> 0.
  function automatic color_t color_next(input color_t c);
    return c + color_t'(1);
  endfunction

endpackage

// File: rtl/color_sequencer_if.sv
// rtl/color_sequencer_if.sv - sync/control inputs and pixel/sync outputs of the colour sequencer
interface color_sequencer_if;
  import color_clock_pkg::*;

  logic   h_sync;
  logic   v_sync;
  logic   onscreen;
  logic   en;
  logic   pause;
  logic   step;
  color_t color;
  logic   frame_tick;
  logic   R;
  logic   G;
  logic   B;
  logic   h_sync_o;
  logic   v_sync_o;

  modport master (
    output h_sync, v_sync, onscreen, en, pause, step,
    input  color, frame_tick, R, G, B, h_sync_o, v_sync_o
  );

  modport slave (
    input  h_sync, v_sync, onscreen, en, pause, step,
    output color, frame_tick, R, G, B, h_sync_o, v_sync_o
  );

endinterface

// File: rtl/frame_tick_det.sv
// rtl/frame_tick_det.sv - registered one-clock pulse on each falling edge of active-low v_sync
module frame_tick_det (
  input  logic clk,
  input  logic rst_n,
  input  logic v_sync,
  output logic frame_tick
);

  logic vs_q;

  // Previous v_sync resets low so a low v_sync at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= v_sync;
      frame_tick <= vs_q & ~v_sync;
    end
  end

endmodule

// File: rtl/color_sequencer.sv
// rtl/color_sequencer.sv - advances the displayed colour after a programmable frame dwell
module color_sequencer
  import color_clock_pkg::*;
#(
  parameter int DWELL_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input logic               clk,
  input logic               rst_n,
  color_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_FRAMES - 1);

  seq_state_t       state_q, state_d;
  color_t           color_q, color_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_pend_q, step_pend_d;
  logic             tick;

  logic             r_q, g_q, b_q;
  logic             h_sync_q, v_sync_q;

  frame_tick_det u_frame_tick_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .v_sync     (bus.v_sync),
    .frame_tick (tick)
  );

  // Sequencer state, colour, dwell counter and pending step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      color_q     <= '0;
      cnt_q       <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      cnt_q       <= cnt_d;
      step_pend_q <= step_pend_d;
    end
  end

  // Next-state: en low wins over everything; a tick is handled by the current
  // state's rules before any pause transition takes effect.
  always_comb begin
    state_d     = state_q;
    color_d     = color_q;
    cnt_d       = cnt_q;
    step_pend_d = step_pend_q;

    if (!bus.en) begin
      state_d     = IDLE;
      color_d     = '0;
      cnt_d       = '0;
      step_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          color_d     = '0;
          cnt_d       = '0;
          step_pend_d = 1'b0;
          state_d     = RUN;
        end
        RUN: begin
          step_pend_d = 1'b0;
          if (tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              color_d = color_next(color_q);
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
          if (bus.pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (tick && step_pend_q) begin
            color_d = color_next(color_q);
          end
          if (bus.pause) begin
            // A step in the tick cycle re-arms for the following tick.
            step_pend_d = bus.step | (step_pend_q & ~tick);
          end else begin
            step_pend_d = 1'b0;
            state_d     = RUN;
          end
        end
        default: begin
          state_d     = IDLE;
          color_d     = '0;
          cnt_d       = '0;
          step_pend_d = 1'b0;
        end
      endcase
    end
  end

  // Pixel and sync output registers share one stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q      <= 1'b0;
      g_q      <= 1'b0;
      b_q      <= 1'b0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
    end else begin
      r_q      <= bus.onscreen & color_q[2];
      g_q      <= bus.onscreen & color_q[1];
      b_q      <= bus.onscreen & color_q[0];
      h_sync_q <= bus.h_sync;
      v_sync_q <= bus.v_sync;
    end
  end

  assign bus.color      = color_q;
  assign bus.frame_tick = tick;
  assign bus.R          = r_q;
  assign bus.G          = g_q;
  assign bus.B          = b_q;
  assign bus.h_sync_o   = h_sync_q;
  assign bus.v_sync_o   = v_sync_q;

endmodule
